// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID-stage hazard FSM state encoding.
package mips_pkg;

   localparam logic [5:0]  OP_SPECIAL = 6'b000000;
   localparam logic [5:0]  OP_J       = 6'b000010;
   localparam logic [5:0]  OP_JAL     = 6'b000011;
   localparam logic [5:0]  OP_BEQ     = 6'b000100;
   localparam logic [5:0]  OP_BNE     = 6'b000101;
   localparam logic [5:0]  FUNCT_JR   = 6'b001000;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect resolution for J/JAL/JR/BEQ/BNE: target address and taken flag.
module branch_target_calc
   import mips_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc4,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] target,
   output logic        taken
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] br_offset;

   assign op        = instr[31:26];
   assign funct     = instr[5:0];
   assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      target = '0;
      taken  = 1'b0;
      case (op)
         OP_J, OP_JAL: begin
            taken  = 1'b1;
            target = {pc4[31:28], instr[25:0], 2'b00};
         end
         OP_BEQ: begin
            taken  = (rs_data == rt_data);
            target = pc4 + br_offset;
         end
         OP_BNE: begin
            taken  = (rs_data != rt_data);
            target = pc4 + br_offset;
         end
         OP_SPECIAL: begin
            if (funct == FUNCT_JR) begin
               taken  = 1'b1;
               target = rs_data;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_hazard_redirect.sv
// Decode-stage hazard stall and control-flow redirect with registered ID/EX hand-off.
// Define HAZARD_STATS_EN to add saturating redirect / stall-cycle counters.
module id_hazard_redirect
   import mips_pkg::*;
#(
   parameter int LOAD_USE_STALL    = 1,
   parameter int ALU_BRANCH_STALL  = 1,
   parameter int LOAD_BRANCH_STALL = 2,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          if_pc_add_four,
   input  logic [31:0]          if_instruction,
   input  logic [31:0]          rs_data,
   input  logic [31:0]          rt_data,
   input  logic                 ex_reg_write,
   input  logic                 ex_mem_read,
   input  logic [4:0]           ex_dest,
   output logic                 PC_mux_sel,
   output logic [31:0]          PC_jump,
   output logic                 stall,
   output logic [31:0]          id_instruction_out,
   output logic [31:0]          id_pc_add_four_out,
`ifdef HAZARD_STATS_EN
   output logic                 id_valid_out,
   output logic [CNT_WIDTH-1:0] stat_redirects,
   output logic [CNT_WIDTH-1:0] stat_stall_cycles
`else
   output logic                 id_valid_out
`endif
);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        id_valid_q, id_valid_d;

   logic [31:0] cur_instr, cur_pc;
   logic        cur_valid;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt;
   logic        is_jr, is_bxx, is_branch, is_jump;
   logic        rs_hit, rt_hit, br_hit, other_hit;
   logic [7:0]  n_stall;
   logic [31:0] target;
   logic        taken;
   logic        stall_int, issue, sel_int;

   assign cur_instr = (state_q == STALL) ? hold_instr_q : if_instruction;
   assign cur_pc    = (state_q == STALL) ? hold_pc_q    : if_pc_add_four;
   assign cur_valid = (cur_instr != NOP);

   assign op    = cur_instr[31:26];
   assign funct = cur_instr[5:0];
   assign rs    = cur_instr[25:21];
   assign rt    = cur_instr[20:16];

   branch_target_calc u_btc (
      .instr   (cur_instr),
      .pc4     (cur_pc),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .target  (target),
      .taken   (taken)
   );

   // J/JAL read no registers; every other non-branch is treated as reading both rs and rt.
   always_comb begin
      is_jr     = (op == OP_SPECIAL) && (funct == FUNCT_JR);
      is_bxx    = (op == OP_BEQ) || (op == OP_BNE);
      is_branch = is_jr || is_bxx;
      is_jump   = (op == OP_J) || (op == OP_JAL);
      rs_hit    = (rs != 5'd0) && (ex_dest == rs);
      rt_hit    = (rt != 5'd0) && (ex_dest == rt);
      br_hit    = rs_hit || (is_bxx && rt_hit);
      other_hit = !is_jump && (rs_hit || rt_hit);
      n_stall   = '0;
      if (is_branch) begin
         if (ex_mem_read && br_hit)
            n_stall = 8'(LOAD_BRANCH_STALL);
         else if (ex_reg_write && br_hit)
            n_stall = 8'(ALU_BRANCH_STALL);
      end else if (ex_mem_read && other_hit) begin
         n_stall = 8'(LOAD_USE_STALL);
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      stall_int    = 1'b0;
      issue        = 1'b0;
      case (state_q)
         RUN: begin
            if (cur_valid && (n_stall != 8'd0)) begin
               stall_int    = 1'b1;
               hold_instr_d = cur_instr;
               hold_pc_d    = cur_pc;
               cnt_d        = n_stall - 8'd1;
               state_d      = STALL;
            end else begin
               issue = cur_valid;
            end
         end
         STALL: begin
            if (cnt_q != 8'd0) begin
               stall_int = 1'b1;
               cnt_d     = cnt_q - 8'd1;
            end else begin
               issue   = cur_valid;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      sel_int    = !stall_int && cur_valid && taken;
      id_instr_d = issue ? cur_instr : NOP;
      id_pc_d    = issue ? cur_pc    : '0;
      id_valid_d = issue;
   end

   // Gating with rst keeps the combinational outputs quiet while reset is held.
   assign stall              = rst && stall_int;
   assign PC_mux_sel         = rst && sel_int;
   assign PC_jump            = PC_mux_sel ? target : '0;
   assign id_instruction_out = id_instr_q;
   assign id_pc_add_four_out = id_pc_q;
   assign id_valid_out       = id_valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RUN;
         cnt_q        <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         id_instr_q   <= '0;
         id_pc_q      <= '0;
         id_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_valid_q   <= id_valid_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      redir_cnt_d = redir_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (PC_mux_sel && (redir_cnt_q != '1))
         redir_cnt_d = redir_cnt_q + 1'b1;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         redir_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         redir_cnt_q <= redir_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stat_redirects    = redir_cnt_q;
   assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_redirect.sv
// Scoreboard bench for id_hazard_redirect: per-cycle expectations queued by the driver, checked by a monitor.
module tb_id_hazard_redirect;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] if_pc_add_four = '0;
   logic [31:0] if_instruction = '0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        ex_reg_write = 1'b0;
   logic        ex_mem_read = 1'b0;
   logic [4:0]  ex_dest = '0;
   logic        PC_mux_sel;
   logic [31:0] PC_jump;
   logic        stall;
   logic [31:0] id_instruction_out;
   logic [31:0] id_pc_add_four_out;
   logic        id_valid_out;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic        sel;
      logic [31:0] jump;
      logic        stl;
      logic [31:0] iid;
      logic [31:0] ipc;
      logic        ival;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [31:0] J_INS    = 32'h0800_0010;
   localparam logic [31:0] BEQ_INS  = 32'h1022_FFFF;
   localparam logic [31:0] ADD_INS  = 32'h0109_5020;
   localparam logic [31:0] BNE_INS  = 32'h152A_0004;
   localparam logic [31:0] JR0_INS  = 32'h0000_0008;
   localparam logic [31:0] JR31_INS = 32'h03E0_0008;
   localparam logic [31:0] GARBAGE  = 32'h0800_0000;

   always #5 clk = ~clk;

   id_hazard_redirect dut (
      .clk                (clk),
      .rst                (rst),
      .if_pc_add_four     (if_pc_add_four),
      .if_instruction     (if_instruction),
      .rs_data            (rs_data),
      .rt_data            (rt_data),
      .ex_reg_write       (ex_reg_write),
      .ex_mem_read        (ex_mem_read),
      .ex_dest            (ex_dest),
      .PC_mux_sel         (PC_mux_sel),
      .PC_jump            (PC_jump),
      .stall              (stall),
      .id_instruction_out (id_instruction_out),
      .id_pc_add_four_out (id_pc_add_four_out),
      .id_valid_out       (id_valid_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; id fields are the values expected after the closing rising edge.
   task automatic drive(input string name, input logic r, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic w, input logic m,
                        input logic [4:0] d, input logic es, input logic [31:0] ej, input logic est,
                        input logic [31:0] ei, input logic [31:0] ep, input logic ev);
      exp_t e;
      @(negedge clk);
      rst = r; if_instruction = ins; if_pc_add_four = pc; rs_data = rsd; rt_data = rtd;
      ex_reg_write = w; ex_mem_read = m; ex_dest = d;
      e.name = name; e.sel = es; e.jump = ej; e.stl = est; e.iid = ei; e.ipc = ep; e.ival = ev;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            check({e.name, ".sel"},   {31'b0, PC_mux_sel}, {31'b0, e.sel});
            check({e.name, ".jump"},  PC_jump, e.jump);
            check({e.name, ".stall"}, {31'b0, stall}, {31'b0, e.stl});
            @(posedge clk);
            #1;
            check({e.name, ".id_instr"}, id_instruction_out, e.iid);
            check({e.name, ".id_pc"},    id_pc_add_four_out, e.ipc);
            check({e.name, ".id_valid"}, {31'b0, id_valid_out}, {31'b0, e.ival});
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin : driver
      int wait_cycles;
      // reset held with a J on IF/ID, then released
      drive("rst0", 0, J_INS, 32'h4, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      drive("rst1", 0, J_INS, 32'h4, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      drive("jrel", 1, J_INS, 32'h4, 0, 0, 0, 0, 0,  1, 32'h40, 0,  J_INS, 32'h4, 1);
      drive("bub1", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      // BEQ taken / not taken
      drive("beqT", 1, BEQ_INS, 32'h104, 5, 5, 0, 0, 0,  1, 32'h100, 0,  BEQ_INS, 32'h104, 1);
      drive("beqN", 1, BEQ_INS, 32'h104, 5, 6, 0, 0, 0,  0, 0, 0,  BEQ_INS, 32'h104, 1);
      drive("bub2", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      // load-use: one stall cycle, one bubble, then the ADD
      drive("lu1",  1, ADD_INS, 32'h200, 0, 0, 1, 1, 8,  0, 0, 1,  0, 0, 0);
      drive("lu2",  1, ADD_INS, 32'h200, 0, 0, 0, 0, 0,  0, 0, 0,  ADD_INS, 32'h200, 1);
      drive("bub3", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      // load-branch: two stall cycles, IF/ID garbage ignored, BNE resolves on the third
      drive("lb1",  1, BNE_INS, 32'h300, 1, 2, 1, 1, 9,  0, 0, 1,  0, 0, 0);
      drive("lb2",  1, GARBAGE, 32'hDEAD_0000, 1, 2, 0, 0, 0,  0, 0, 1,  0, 0, 0);
      drive("lb3",  1, GARBAGE, 32'hDEAD_0000, 1, 2, 0, 0, 0,  1, 32'h310, 0,  BNE_INS, 32'h300, 1);
      drive("bub4", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      // JR $0 never hazards on r0
      drive("jr0",  1, JR0_INS, 32'h400, 32'h1234, 0, 1, 0, 0,  1, 32'h1234, 0,  JR0_INS, 32'h400, 1);
      drive("bub5", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      // JR $31 behind an ALU write: one stall, then redirect
      drive("jr31a", 1, JR31_INS, 32'h500, 32'h5678, 0, 1, 0, 31,  0, 0, 1,  0, 0, 0);
      drive("jr31b", 1, JR31_INS, 32'h500, 32'h5678, 0, 0, 0, 0,  1, 32'h5678, 0,  JR31_INS, 32'h500, 1);
      drive("bub6", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      // ALU producer feeding a non-branch needs no stall
      drive("alu",  1, ADD_INS, 32'h600, 0, 0, 1, 0, 8,  0, 0, 0,  ADD_INS, 32'h600, 1);
      // async reset in the middle of a load-branch stall
      drive("rs1",  1, BNE_INS, 32'h700, 1, 2, 1, 1, 9,  0, 0, 1,  0, 0, 0);
      drive("rs2",  1, 0, 0, 1, 2, 0, 0, 0,  0, 0, 1,  0, 0, 0);
      #3 rst = 1'b0;
      #1;
      check("rst_mid.stall", {31'b0, stall}, 32'h0);
      check("rst_mid.sel",   {31'b0, PC_mux_sel}, 32'h0);
      drive("rs3",  0, 0, 0, 1, 2, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      drive("rs4",  1, 0, 0, 1, 2, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      drive("rs5",  1, 0, 0, 1, 2, 0, 0, 0,  0, 0, 0,  0, 0, 0);
      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      #20;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_hazard_redirect.md
Name: id_hazard_redirect

Overview:
- Decode-side consumer of the fetch stage's IF/ID outputs (`PC_add_four_out`, `instruction_out`).
- Produces the control inputs fetch consumes: `PC_mux_sel`, `PC_jump`, `stall`.
- Resolves J/JAL/JR/BEQ/BNE in ID and detects register hazards against EX.
- Holds the stalled instruction internally and drives a registered ID/EX hand-off (instruction, PC+4, valid) to the execute stage.

Parameters:
- LOAD_USE_STALL, 1: bubble cycles when a non-branch instruction reads the rt of a load in EX.
- ALU_BRANCH_STALL, 1: bubble cycles when a branch/JR reads the destination of an ALU op in EX.
- LOAD_BRANCH_STALL, 2: bubble cycles when a branch/JR reads the rt of a load in EX.
- CNT_WIDTH, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc_add_four  in  32  PC+4 from IF/ID.
- if_instruction  in  32  instruction from IF/ID; 0 = bubble.
- rs_data  in  32  register-file read of instr[25:21].
- rt_data  in  32  register-file read of instr[20:16].
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_dest  in  5  EX destination register number.
- PC_mux_sel  out  1  redirect fetch to PC_jump (combinational).
- PC_jump  out  32  redirect target (combinational).
- stall  out  1  freeze fetch PC (combinational from state).
- id_instruction_out  out  32  registered ID/EX instruction.
- id_pc_add_four_out  out  32  registered ID/EX PC+4.
- id_valid_out  out  1  registered; 1 = real instruction in ID/EX.

Behaviour:
- Reset (rst=0, async): state RUN, stall counter 0, hold register 0; `id_instruction_out`=0, `id_pc_add_four_out`=0, `id_valid_out`=0. Combinationally `PC_mux_sel`=0, `PC_jump`=0, `stall`=0.
- Current instruction `cur`:
  - In RUN, `cur` = `if_instruction` / `if_pc_add_four`.
  - In STALL, `cur` = held copy; the IF/ID inputs are ignored.
- `cur` is valid when nonzero.
- Decode:
  - J: op=000010.
  - JAL: op=000011.
  - JR: op=0 and funct=001000.
  - BEQ: op=000100.
  - BNE: op=000101.
  - A "branch-class" instruction is BEQ, BNE or JR; these read rs, and BEQ/BNE also read rt.
- Hazard: source register r≠0, `ex_dest`==r, and either `ex_reg_write` or `ex_mem_read` is set. Stall length n:
  - LOAD_BRANCH_STALL for branch-class with EX load.
  - ALU_BRANCH_STALL for branch-class with EX ALU write.
  - LOAD_USE_STALL for other instructions with EX load.
  - 0 otherwise.
- Hazard priority: load beats ALU.
- FSM RUN:
  - Valid `cur` with n>0: latch `cur` into hold, counter←n-1, go STALL.
  - `stall`=1 in the same cycle.
  - Next ID/EX = bubble: all 0, valid=0.
- FSM STALL:
  - `stall`=1 while counter>0; counter decrements each cycle.
  - EX inputs are not re-evaluated; the counter alone governs.
  - When counter==0: `stall`=0, held `cur` is resolved and issued, go RUN.
  - The following cycle consumes IF/ID again.
- Redirect: when not stalling and `cur` is valid, `PC_mux_sel`=1 for:
  - J, JAL;
  - JR;
  - BEQ with rs_data==rt_data;
  - BNE with rs_data≠rt_data.
- Redirect targets:
  - J/JAL: {pc4[31:28], instr[25:0], 2'b00}.
  - JR: rs_data.
  - Branch: pc4 + (signext(imm16)<<2), mod 2^32.
  - `PC_jump`=0 when `PC_mux_sel`=0.
- `PC_mux_sel` and `stall` are never both 1.
- A taken control instruction is still issued to ID/EX (JAL needs its link). Fetch flushes IF/ID on redirect, so the next `cur` is a bubble.
- ID/EX register updates every rising edge: issued `cur`, or a bubble if stalling or `cur` is invalid.
- Reset mid-stall: returns to RUN and discards the held instruction.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With the macro:
  - Adds ports `stat_redirects` (out, CNT_WIDTH) and `stat_stall_cycles` (out, CNT_WIDTH).
  - Each counter increments on every cycle its event occurs, is cleared by reset, and saturates at all-ones.
- Without the macro: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package `mips_pkg`:
  - opcode/funct constants (OP_J, OP_JAL, OP_BEQ, OP_BNE, FUNCT_JR);
  - NOP=32'h0;
  - FSM state encoding (RUN, STALL).
- One sub-module, `branch_target_calc`: purely combinational, computes PC_jump and taken from instr, pc4, rs_data, rt_data.

Test Plan:
- Reset release:
  - Stimulus: rst low while `if_instruction`=32'h08000010.
  - Required: all outputs 0.
  - After rst high with that input: `PC_mux_sel`=1, `PC_jump`=32'h00000040; next edge `id_valid_out`=1.
- BEQ taken/not-taken:
  - Stimulus: pc4=32'h00000104, imm=16'hFFFF, rs_data=rt_data=5.
  - Required: `PC_jump`=32'h00000100.
  - With rt_data=6: `PC_mux_sel`=0.
- Load-use:
  - Stimulus: ADD reading $8; `ex_mem_read`=1, `ex_dest`=8.
  - Required: `stall`=1 for exactly 1 cycle; one bubble with `id_valid_out`=0; then ADD issued.
- Load-branch:
  - Stimulus: BNE on $9; EX load to $9; IF/ID changed to garbage during the stall.
  - Required: `stall`=1 for 2 cycles; the held BNE resolves on cycle 3; garbage is ignored.
- JR with r0 and ALU hazard:
  - JR $0 with `ex_dest`=0: no stall, `PC_jump`=rs_data.
  - JR $31 with `ex_reg_write`, `ex_dest`=31: 1-cycle stall, then redirect.
- Async reset mid-stall:
  - Stimulus: assert rst during the LOAD_BRANCH_STALL count.
  - Required: `stall` drops immediately; after release the held instruction is never issued.
